// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM state encodings, palette and frame geometry for the pong frame controller.
package pong_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
    localparam logic [11:0] COL_TEXT   = 12'hFFF;
    localparam logic [11:0] COL_BALL   = 12'hF00;
    localparam logic [11:0] COL_PADDLE = 12'h0F0;
    localparam logic [11:0] COL_WALL   = 12'h00F;
    localparam logic [11:0] COL_BG     = 12'h111;
    localparam logic [11:0] COL_OFF    = 12'h000;
    localparam logic [9:0]  FRAME_Y    = 10'd480;
    localparam logic [9:0]  H_TOTAL    = 10'd800;
    localparam logic [9:0]  V_TOTAL    = 10'd525;
endpackage

// File: rtl/pong_pixel_mux.sv
// pong_pixel_mux: registered priority mux choosing the pixel colour from the layer hit flags.
// Ports: clk, rst (sync, active-high); video_on, text_en (text layer allowed), text_on,
//        ball_on, paddle_on, wall_on -> rgb (12-bit 4:4:4, one cycle latency).
module pong_pixel_mux
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        video_on,
    input  logic        text_en,
    input  logic        text_on,
    input  logic        ball_on,
    input  logic        paddle_on,
    input  logic        wall_on,
    output logic [11:0] rgb
);
    logic [11:0] rgb_n;
    always_comb
        rgb_n = !video_on             ? COL_OFF    :
                (text_en && text_on)  ? COL_TEXT   :
                ball_on               ? COL_BALL   :
                paddle_on             ? COL_PADDLE :
                wall_on               ? COL_WALL   : COL_BG;
    always_ff @(posedge clk)
        rgb <= rst ? COL_OFF : rgb_n;
endmodule

// File: rtl/pong_frame_ctrl.sv
// pong_frame_ctrl: game-state FSM, frame timer and pixel colour output for a pong game.
// Ports: clk_25MHz, reset (sync, active-high); pixelX/pixelY, videoOn from the sync generator;
//        btnStart (level), missEvent (pulse), layer flags textOn/ballOn/paddleOn/wallOn;
//        outputs rgb, refreshTick, updateEn, ballReset, ballsLeft, state.
module pong_frame_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int NUM_BALLS    = 3
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic [9:0]  pixelX,
    input  logic [9:0]  pixelY,
    input  logic        videoOn,
    input  logic        btnStart,
    input  logic        missEvent,
    input  logic        textOn,
    input  logic        ballOn,
    input  logic        paddleOn,
    input  logic        wallOn,
    output logic [11:0] rgb,
    output logic        refreshTick,
    output logic        updateEn,
    output logic        ballReset,
    output logic [1:0]  ballsLeft,
    output logic [1:0]  state
);
    // The 8-bit timer must reach the last frame without wrapping; ballsLeft is 2 bits.
    if (SERVE_FRAMES < 1 || SERVE_FRAMES > 255 || OVER_FRAMES < 1 || OVER_FRAMES > 255 ||
        NUM_BALLS < 1 || NUM_BALLS > 3) begin : g_bad_param
        $error("pong_frame_ctrl: parameter out of range");
    end
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
    localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
    state_t     state_q, state_n;
    logic [7:0] timer_q, timer_n;
    logic [1:0] balls_q, balls_n;
    logic       btn_q, start_pulse;
    assign refreshTick = (pixelX == 10'd0) && (pixelY == FRAME_Y);
    assign start_pulse = btnStart && !btn_q;
    assign updateEn    = refreshTick && (state_q == PLAY);
    assign ballReset   = (state_q == IDLE) || (state_q == SERVE);
    assign ballsLeft   = balls_q;
    assign state       = state_q;
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            balls_q <= BALLS_INIT;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            balls_q <= balls_n;
            btn_q   <= btnStart;
        end
    end
    // missEvent is only examined in PLAY, so it wins over a coincident refreshTick there.
    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        balls_n = balls_q;
        case (state_q)
            IDLE: begin
                balls_n = BALLS_INIT;
                if (start_pulse) begin
                    state_n = SERVE;
                    timer_n = '0;
                end
            end
            SERVE: if (refreshTick) begin
                timer_n = (timer_q == SERVE_LAST) ? 8'd0 : timer_q + 8'd1;
                state_n = (timer_q == SERVE_LAST) ? PLAY : SERVE;
            end
            PLAY: if (missEvent) begin
                timer_n = '0;
                balls_n = (balls_q > 2'd1) ? balls_q - 2'd1 : 2'd0;
                state_n = (balls_q > 2'd1) ? SERVE : OVER;
            end
            OVER: if (refreshTick) begin
                timer_n = (timer_q == OVER_LAST) ? 8'd0 : timer_q + 8'd1;
                state_n = (timer_q == OVER_LAST) ? IDLE : OVER;
            end
            default: state_n = IDLE;
        endcase
    end
    pong_pixel_mux u_mux (
        .clk       (clk_25MHz),
        .rst       (reset),
        .video_on  (videoOn),
        .text_en   ((state_q == IDLE) || (state_q == OVER)),
        .text_on   (textOn),
        .ball_on   (ballOn),
        .paddle_on (paddleOn),
        .wall_on   (wallOn),
        .rgb       (rgb)
    );
endmodule
